// File: rtl/jelly_graycode_decode_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// jelly_graycode_decode_arbiter_pkg
//   Shared helpers for the Gray-decode arbiter slice.
//   rr_index : position 'offset' steps after 'base' in a ring of 'num'
//              entries. The arbiter uses it to walk requesters in
//              round-robin order starting just after the last winner.
// ---------------------------------------------------------------------------
package jelly_graycode_decode_arbiter_pkg;

    function automatic int rr_index(input int base, input int offset, input int num);
        int sum;
        sum = base + offset;
        // offset never exceeds num, so a single wrap is enough
        if (sum >= num) begin
            sum = sum - num;
        end
        return sum;
    endfunction

endpackage

// File: rtl/jelly_graycode_to_binary.sv
// ---------------------------------------------------------------------------
// jelly_graycode_to_binary
//   Purely combinational Gray-to-binary converter.
//   Ports:
//     gray   [WIDTH-1:0]  Gray-coded input word
//     binary [WIDTH-1:0]  binary equivalent
// ---------------------------------------------------------------------------
module jelly_graycode_to_binary #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] binary
);

    // binary[i] = binary[i+1] ^ gray[i] unrolls to the XOR of every Gray bit
    // at or above i; writing it that way avoids a self-referencing vector.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign binary[i] = ^gray[WIDTH-1:i];
    end

endmodule

// File: rtl/jelly_graycode_decode_arbiter.sv
// ---------------------------------------------------------------------------
// jelly_graycode_decode_arbiter
//   Shares one Gray-to-binary decoder among NUM requesters. A round-robin
//   arbiter picks one valid requester per cycle; its word is captured in
//   stage 0, decoded into stage 1, and presented on the master port tagged
//   with the requester index.
//   Ports:
//     reset       sync, active-high reset
//     clk         rising-edge clock
//     cke         clock enable; 0 holds all state and drops s_ready
//     s_graycode  NUM packed Gray words, requester i at [i*WIDTH +: WIDTH]
//     s_valid     per-requester valid
//     s_ready     per-requester ready (one-hot or zero)
//     m_id        requester index of the presented result
//     m_binary    decoded binary value
//     m_valid     result valid
//     m_ready     downstream accept
// ---------------------------------------------------------------------------
module jelly_graycode_decode_arbiter
    import jelly_graycode_decode_arbiter_pkg::*;
#(
    parameter int NUM      = 4,
    parameter int WIDTH    = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic                    reset,
    input  logic                    clk,
    input  logic                    cke,

    input  logic [NUM*WIDTH-1:0]    s_graycode,
    input  logic [NUM-1:0]          s_valid,
    output logic [NUM-1:0]          s_ready,

    output logic [ID_WIDTH-1:0]     m_id,
    output logic [WIDTH-1:0]        m_binary,
    output logic                    m_valid,
    input  logic                    m_ready
);

    localparam logic [ID_WIDTH-1:0] LAST_GRANT_INIT = ID_WIDTH'(NUM - 1);

    logic [ID_WIDTH-1:0]    last_grant;

    logic                   st0_valid;
    logic [ID_WIDTH-1:0]    st0_id;
    logic [WIDTH-1:0]       st0_gray;

    logic [NUM-1:0]         grant;
    logic [ID_WIDTH-1:0]    grant_id;
    logic [WIDTH-1:0]       grant_gray;
    logic                   grant_any;

    logic                   st1_load;
    logic                   st0_accept;
    logic                   transfer;
    logic [WIDTH-1:0]       st0_binary;

    // Round-robin search: first valid requester after last_grant, wrapping.
    always_comb begin
        int idx;
        grant      = '0;
        grant_id   = '0;
        grant_gray = '0;
        grant_any  = 1'b0;
        for (int k = 1; k <= NUM; k++) begin
            idx = rr_index(int'(last_grant), k, NUM);
            if (!grant_any && s_valid[idx]) begin
                grant[idx] = 1'b1;
                grant_id   = ID_WIDTH'(idx);
                grant_gray = s_graycode[idx*WIDTH +: WIDTH];
                grant_any  = 1'b1;
            end
        end
    end

    assign st1_load   = cke & (~m_valid | m_ready);
    assign st0_accept = cke & (~st0_valid | st1_load);

    // Held low through reset cycles so nothing is handed over while the
    // pipeline is being cleared.
    assign s_ready    = (st0_accept && !reset) ? grant : '0;
    assign transfer   = st0_accept & grant_any & ~reset;

    // Priority pointer moves only on an actual handover, never on idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= LAST_GRANT_INIT;
        end else if (transfer) begin
            last_grant <= grant_id;
        end
    end

    // Stage 0: capture
    always_ff @(posedge clk) begin
        if (reset) begin
            st0_valid <= 1'b0;
            st0_id    <= '0;
            st0_gray  <= '0;
        end else if (st0_accept) begin
            st0_valid <= grant_any;
            if (grant_any) begin
                st0_id   <= grant_id;
                st0_gray <= grant_gray;
            end
        end
    end

    jelly_graycode_to_binary #(
        .WIDTH  (WIDTH)
    ) u_decode (
        .gray   (st0_gray),
        .binary (st0_binary)
    );

    // Stage 1: decoded output, held while stalled
    always_ff @(posedge clk) begin
        if (reset) begin
            m_valid  <= 1'b0;
            m_id     <= '0;
            m_binary <= '0;
        end else if (st1_load) begin
            m_valid  <= st0_valid;
            m_id     <= st0_id;
            m_binary <= st0_binary;
        end
    end

endmodule
